// File: rtl/arm_pkg.sv
// arm_pkg: constants and types shared by the ID-stage control logic.
//   - exe_cmd encodings driven to the EXE-stage ALU
//   - ARM data-processing opcodes (instr[24:21]) and condition codes (instr[31:28])
//   - bit positions of N, Z, C, V inside the 4-bit {N,Z,C,V} status vector
//   - the registered control bundle carried across the ID/EXE boundary
package arm_pkg;

  // ALU commands
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Flag positions in {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Instruction class from instr[27:26]
  typedef enum logic [1:0] {
    FMT_DP  = 2'b00,
    FMT_MEM = 2'b01,
    FMT_BR  = 2'b10,
    FMT_BAD = 2'b11
  } instr_fmt_e;

  // Control bits that are zeroed for a bubble
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against a {N,Z,C,V} flag vector.
//   cond  in  4  instr[31:28]
//   flags in  4  {N,Z,C,V}
//   pass  out 1  instruction is allowed to execute
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // 1111 never executes
    endcase
  end

endmodule

// File: rtl/id_exe_ctrl.sv
// id_exe_ctrl: ID-stage decode, condition evaluation, NZCV status register and
// the ID/EXE pipeline register for the 5-stage ARM pipeline.
//   clk, rst            clock; asynchronous active-high reset
//   instr, instr_valid  instruction from the IF/ID register
//   hazard              insert a bubble (data hazard)
//   freeze              hold every registered output and sr (memory stall)
//   flush               kill the instruction in ID (taken branch in EXE)
//   flags_in, exe_s     ALU flags and whether the EXE instruction sets them
//   exe_cmd .. dest     registered control / data fields for EXE
//   sr                  status register {N,Z,C,V}
//   two_src             combinational: second source register is read
module id_exe_ctrl
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        hazard,
  input  logic        freeze,
  input  logic        flush,
  input  logic [3:0]  flags_in,
  input  logic        exe_s,
  output logic [3:0]  exe_cmd,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en,
  output logic        b,
  output logic        s,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] imm24,
  output logic [3:0]  dest,
  output logic [3:0]  sr,
  output logic        two_src
);

  instr_fmt_e fmt;
  logic [3:0] opcode;
  ctrl_t      dec_ctrl;
  logic       dec_ok;
  logic       sr_write;
  logic [3:0] eff_flags;
  logic       cond_pass;

  ctrl_t      ctrl_q, ctrl_d;
  logic       imm_q, imm_d;
  logic [11:0] shift_q, shift_d;
  logic [23:0] imm24_q, imm24_d;
  logic [3:0] dest_q, dest_d;
  logic [3:0] sr_q, sr_d;

  assign fmt    = instr_fmt_e'(instr[27:26]);
  assign opcode = instr[24:21];

  // The EXE instruction's flags are forwarded so a condition in ID sees
  // the same value sr will hold after this edge.
  assign sr_write  = exe_s & ~freeze;
  assign eff_flags = sr_write ? flags_in : sr_q;

  cond_check u_cond_check (
    .cond  (instr[31:28]),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  // Raw decode, independent of validity, hazards and condition
  always_comb begin
    dec_ctrl = '0;
    dec_ok   = 1'b0;
    case (fmt)
      FMT_DP: begin
        dec_ok         = 1'b1;
        dec_ctrl.wb_en = 1'b1;
        dec_ctrl.s     = instr[20];
        case (opcode)
          OP_MOV:  dec_ctrl.exe_cmd = CMD_MOV;
          OP_MVN:  dec_ctrl.exe_cmd = CMD_MVN;
          OP_ADD:  dec_ctrl.exe_cmd = CMD_ADD;
          OP_ADC:  dec_ctrl.exe_cmd = CMD_ADC;
          OP_SUB:  dec_ctrl.exe_cmd = CMD_SUB;
          OP_SBC:  dec_ctrl.exe_cmd = CMD_SBC;
          OP_AND:  dec_ctrl.exe_cmd = CMD_AND;
          OP_ORR:  dec_ctrl.exe_cmd = CMD_ORR;
          OP_EOR:  dec_ctrl.exe_cmd = CMD_EOR;
          OP_CMP: begin
            dec_ctrl.exe_cmd = CMD_SUB;
            dec_ctrl.wb_en   = 1'b0;
            dec_ctrl.s       = 1'b1;
          end
          OP_TST: begin
            dec_ctrl.exe_cmd = CMD_AND;
            dec_ctrl.wb_en   = 1'b0;
            dec_ctrl.s       = 1'b1;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      FMT_MEM: begin
        dec_ok           = 1'b1;
        dec_ctrl.exe_cmd = CMD_ADD;  // address = base + offset
        dec_ctrl.mem_r_en = instr[20];
        dec_ctrl.mem_w_en = ~instr[20];
        dec_ctrl.wb_en    = instr[20];
      end
      FMT_BR: begin
        dec_ok     = instr[25];
        dec_ctrl.b = instr[25];
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Register-operand DP ops other than MOV/MVN read Rm; STR reads Rd as data.
  assign two_src = ((fmt == FMT_DP) && !instr[25] && (opcode != OP_MOV) && (opcode != OP_MVN))
                || ((fmt == FMT_MEM) && !instr[20]);

  always_comb begin
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    shift_d = shift_q;
    imm24_d = imm24_q;
    dest_d  = dest_q;
    sr_d    = sr_write ? flags_in : sr_q;

    // A flush overrides freeze; data fields follow ID whenever the stage moves.
    if (flush || !freeze) begin
      imm_d   = instr[25];
      shift_d = instr[11:0];
      imm24_d = instr[23:0];
      dest_d  = instr[15:12];
    end

    if (flush) begin
      ctrl_d = '0;
    end else if (!freeze) begin
      if (instr_valid && !hazard && cond_pass && dec_ok) begin
        ctrl_d = dec_ctrl;
      end else begin
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      imm_q   <= 1'b0;
      shift_q <= '0;
      imm24_q <= '0;
      dest_q  <= '0;
      sr_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      shift_q <= shift_d;
      imm24_q <= imm24_d;
      dest_q  <= dest_d;
      sr_q    <= sr_d;
    end
  end

  assign exe_cmd       = ctrl_q.exe_cmd;
  assign mem_r_en      = ctrl_q.mem_r_en;
  assign mem_w_en      = ctrl_q.mem_w_en;
  assign wb_en         = ctrl_q.wb_en;
  assign b             = ctrl_q.b;
  assign s             = ctrl_q.s;
  assign imm           = imm_q;
  assign shift_operand = shift_q;
  assign imm24         = imm24_q;
  assign dest          = dest_q;
  assign sr            = sr_q;

endmodule

// File: tb/tb_id_exe_ctrl.sv
// tb_id_exe_ctrl: directed vectors with literal expectations plus a
// behavioural model of the ID/EXE stage that is compared on every falling edge.
module tb_id_exe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, hazard, freeze, flush, exe_s;
  logic [3:0]  flags_in;
  logic [3:0]  exe_cmd, dest, sr;
  logic        mem_r_en, mem_w_en, wb_en, b, s, imm, two_src;
  logic [11:0] shift_operand;
  logic [23:0] imm24;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_exe_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .hazard(hazard), .freeze(freeze), .flush(flush), .flags_in(flags_in),
    .exe_s(exe_s), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en(wb_en), .b(b), .s(s), .imm(imm), .shift_operand(shift_operand),
    .imm24(imm24), .dest(dest), .sr(sr), .two_src(two_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  cmd;
    logic        r, w, wb, br, sf, im;
    logic [11:0] shift;
    logic [23:0] off;
    logic [3:0]  rd;
    logic [3:0]  sr;
  } model_t;

  model_t m;

  // ALU command for a DP opcode, -1 when the opcode is not supported
  function automatic int dp_cmd(input logic [3:0] op);
    case (op)
      4'hD: return 1;  4'hF: return 9;
      4'h4: return 2;  4'h5: return 3;
      4'h2: return 4;  4'h6: return 5;
      4'h0: return 6;  4'hC: return 7;
      4'h1: return 8;  4'hA: return 4;
      4'h8: return 6;
      default: return -1;
    endcase
  endfunction

  // Conditions come in complementary pairs; odd codes below AL invert the even one.
  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cond != 4'hE && cond[0]) r = !r;
    return r;
  endfunction

  function automatic bit exp_two_src(input logic [31:0] i);
    if (i[27:26] == 2'b00 && !i[25] && i[24:21] != 4'hD && i[24:21] != 4'hF) return 1'b1;
    if (i[27:26] == 2'b01 && !i[20]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [31:0] i,
                                        input logic v, h, fz, fl, es, input logic [3:0] f);
    model_t nx;
    logic [3:0] eff;
    int cmd;
    nx  = cur;
    eff = (es && !fz) ? f : cur.sr;
    if (es && !fz) nx.sr = f;
    if (fl || !fz) begin
      nx.im = i[25]; nx.shift = i[11:0]; nx.off = i[23:0]; nx.rd = i[15:12];
    end
    if (fl || !fz) begin
      nx.cmd = 4'd0; nx.r = 0; nx.w = 0; nx.wb = 0; nx.br = 0; nx.sf = 0;
      if (!fl && v && !h && cond_ok(i[31:28], eff)) begin
        if (i[27:26] == 2'b00) begin
          cmd = dp_cmd(i[24:21]);
          if (cmd >= 0) begin
            nx.cmd = 4'(cmd);
            if (i[24:21] == 4'hA || i[24:21] == 4'h8) begin
              nx.wb = 0; nx.sf = 1;
            end else begin
              nx.wb = 1; nx.sf = i[20];
            end
          end
        end else if (i[27:26] == 2'b01) begin
          nx.cmd = 4'd2; nx.r = i[20]; nx.w = !i[20]; nx.wb = i[20];
        end else if (i[27:26] == 2'b10 && i[25]) begin
          nx.br = 1;
        end
      end
    end
    return nx;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, instr, instr_valid, hazard, freeze, flush, exe_s, flags_in);
  end

  // Compare process: outputs are stable between edges
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("m_exe_cmd", {28'd0, exe_cmd}, {28'd0, m.cmd});
      chk("m_mem_r_en", {31'd0, mem_r_en}, {31'd0, m.r});
      chk("m_mem_w_en", {31'd0, mem_w_en}, {31'd0, m.w});
      chk("m_wb_en", {31'd0, wb_en}, {31'd0, m.wb});
      chk("m_b", {31'd0, b}, {31'd0, m.br});
      chk("m_s", {31'd0, s}, {31'd0, m.sf});
      chk("m_imm", {31'd0, imm}, {31'd0, m.im});
      chk("m_shift", {20'd0, shift_operand}, {20'd0, m.shift});
      chk("m_imm24", {8'd0, imm24}, {8'd0, m.off});
      chk("m_dest", {28'd0, dest}, {28'd0, m.rd});
      chk("m_sr", {28'd0, sr}, {28'd0, m.sr});
      chk("m_two_src", {31'd0, two_src}, {31'd0, exp_two_src(instr)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [31:0] i, input logic v, input logic h, input logic fz,
                     input logic fl, input logic [3:0] f, input logic es);
    instr = i; instr_valid = v; hazard = h; freeze = fz; flush = fl;
    flags_in = f; exe_s = es;
    @(posedge clk);
    #2;
    $display("txn instr=%08h v=%0b hz=%0b fz=%0b fl=%0b es=%0b f=%04b -> cmd=%04b r=%0b w=%0b wb=%0b b=%0b s=%0b sr=%04b",
             i, v, h, fz, fl, es, f, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, sr);
  endtask

  typedef struct {
    logic [31:0] i;
    logic [3:0]  cmd;
    logic        wb;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] flag_pats[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr = '0; instr_valid = 0; hazard = 0; freeze = 0; flush = 0;
    flags_in = '0; exe_s = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_exe_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_sr", {28'd0, sr}, 32'd0);
    chk("rst_dest", {28'd0, dest}, 32'd0);
    chk("rst_imm24", {8'd0, imm24}, 32'd0);
    rst = 1'b0;

    // ADDS R1,R2,#5
    cyc(32'hE2921005, 1, 0, 0, 0, 4'h0, 0);
    chk("adds_cmd", {28'd0, exe_cmd}, 32'h2);
    chk("adds_wb", {31'd0, wb_en}, 32'd1);
    chk("adds_s", {31'd0, s}, 32'd1);
    chk("adds_imm", {31'd0, imm}, 32'd1);
    chk("adds_dest", {28'd0, dest}, 32'd1);

    // CMP R1,#0 then BEQ with same-cycle flag bypass
    cyc(32'hE3510000, 1, 0, 0, 0, 4'h0, 0);
    chk("cmp_cmd", {28'd0, exe_cmd}, 32'h4);
    chk("cmp_wb", {31'd0, wb_en}, 32'd0);
    chk("cmp_s", {31'd0, s}, 32'd1);
    cyc(32'h0A000003, 1, 0, 0, 0, 4'b0100, 1);
    chk("beq_b", {31'd0, b}, 32'd1);
    chk("beq_imm24", {8'd0, imm24}, 32'h000003);
    chk("beq_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("beq_sr", {28'd0, sr}, 32'h4);

    // MOVNE with Z set: bubble, data fields still load
    cyc(32'h13A01001, 1, 0, 0, 0, 4'h0, 0);
    chk("movne_z_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("movne_z_wb", {31'd0, wb_en}, 32'd0);
    chk("movne_z_dest", {28'd0, dest}, 32'd1);
    cyc(32'h00000000, 0, 0, 0, 0, 4'h0, 1);
    chk("sr_clear", {28'd0, sr}, 32'd0);
    cyc(32'h13A01001, 1, 0, 0, 0, 4'h0, 0);
    chk("movne_cmd", {28'd0, exe_cmd}, 32'h1);
    chk("movne_wb", {31'd0, wb_en}, 32'd1);

    // LDR / STR
    cyc(32'hE5921000, 1, 1, 0, 0, 4'h0, 0);
    chk("ldr_hz_r", {31'd0, mem_r_en}, 32'd0);
    chk("ldr_hz_cmd", {28'd0, exe_cmd}, 32'd0);
    cyc(32'hE5921000, 1, 0, 0, 0, 4'h0, 0);
    chk("ldr_r", {31'd0, mem_r_en}, 32'd1);
    chk("ldr_cmd", {28'd0, exe_cmd}, 32'h2);
    chk("ldr_wb", {31'd0, wb_en}, 32'd1);
    chk("ldr_two_src", {31'd0, two_src}, 32'd0);
    cyc(32'hE5821000, 1, 0, 0, 0, 4'h0, 0);
    chk("str_w", {31'd0, mem_w_en}, 32'd1);
    chk("str_wb", {31'd0, wb_en}, 32'd0);
    chk("str_two_src", {31'd0, two_src}, 32'd1);

    // Freeze for 3 cycles with a pending flag update: everything holds
    for (int k = 0; k < 3; k++) begin
      cyc(32'hE2921005, 1, 0, 1, 0, 4'hF, 1);
      chk("frz_w", {31'd0, mem_w_en}, 32'd1);
      chk("frz_cmd", {28'd0, exe_cmd}, 32'h2);
      chk("frz_imm", {31'd0, imm}, 32'd0);
      chk("frz_sr", {28'd0, sr}, 32'd0);
    end
    // Flush during freeze: bubble, data loads, sr still frozen
    cyc(32'hE2921005, 1, 0, 1, 1, 4'hF, 1);
    chk("frz_fl_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("frz_fl_w", {31'd0, mem_w_en}, 32'd0);
    chk("frz_fl_imm", {31'd0, imm}, 32'd1);
    chk("frz_fl_sr", {28'd0, sr}, 32'd0);
    // Flush with a flag update: sr still takes the older instruction's flags
    cyc(32'hE2921005, 1, 0, 0, 1, 4'b1001, 1);
    chk("fl_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("fl_sr", {28'd0, sr}, 32'h9);

    // Opcode table, invalid encodings and instr_valid
    vecs[0] = '{32'hE3E01000, 4'h9, 1'b1};  // MVN
    vecs[1] = '{32'hE0A12003, 4'h3, 1'b1};  // ADC
    vecs[2] = '{32'hE0C12003, 4'h5, 1'b1};  // SBC
    vecs[3] = '{32'hE0212003, 4'h8, 1'b1};  // EOR
    vecs[4] = '{32'hE1812003, 4'h7, 1'b1};  // ORR
    vecs[5] = '{32'hE0412003, 4'h4, 1'b1};  // SUB
    vecs[6] = '{32'hE0012003, 4'h6, 1'b1};  // AND
    vecs[7] = '{32'hE0612003, 4'h0, 1'b0};  // RSB: unsupported
    vecs[8] = '{32'hEC000000, 4'h0, 1'b0};  // class 11
    vecs[9] = '{32'hE8000000, 4'h0, 1'b0};  // class 10 without I
    for (int k = 0; k < 10; k++) begin
      cyc(vecs[k].i, 1, 0, 0, 0, 4'h0, 0);
      chk("tbl_cmd", {28'd0, exe_cmd}, {28'd0, vecs[k].cmd});
      chk("tbl_wb", {31'd0, wb_en}, {31'd0, vecs[k].wb});
    end
    cyc(32'hE2921005, 0, 0, 0, 0, 4'h0, 0);
    chk("invalid_cmd", {28'd0, exe_cmd}, 32'd0);

    // Every condition code against several bypassed flag patterns
    flag_pats = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h9, 4'hB};
    for (int fi = 0; fi < 8; fi++) begin
      for (int c = 0; c < 16; c++) begin
        cyc({c[3:0], 28'h0810001}, 1, 0, 0, 0, flag_pats[fi], 1);
      end
    end
    chk("cond_sr", {28'd0, sr}, 32'hB);

    // Reset asserted between edges while frozen
    cyc(32'hE2921005, 1, 0, 1, 0, 4'h0, 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("mid_rst_wb", {31'd0, wb_en}, 32'd0);
    chk("mid_rst_dest", {28'd0, dest}, 32'd0);
    chk("mid_rst_sr", {28'd0, sr}, 32'd0);
    rst = 1'b0;

    // TST R0,R2 on the first edge after reset
    cyc(32'hE1100002, 1, 0, 0, 0, 4'h0, 0);
    chk("tst_cmd", {28'd0, exe_cmd}, 32'h6);
    chk("tst_s", {31'd0, s}, 32'd1);
    chk("tst_wb", {31'd0, wb_en}, 32'd0);
    chk("tst_two_src", {31'd0, two_src}, 32'd1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_ctrl.md
# id_exe_ctrl

ID-stage control and issue block for the 5-stage ARM pipeline: it decodes the fetched instruction into the execute command and control bits consumed by the EXE-stage ALU, memory and write-back logic. It also owns the NZCV status register, which is fed back from the ALU flag outputs. It evaluates the instruction condition field and registers all control into the ID/EXE boundary, including bubble, stall and flush handling. It sits between the IF/ID register and the ALU/EXE stage.

## Interface
- No parameters.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction from IF/ID register
- instr_valid  in  1  instr holds a real instruction
- hazard  in  1  hazard unit: data hazard, insert bubble
- freeze  in  1  memory stall: hold all registered outputs and SR
- flush  in  1  branch taken in EXE: kill instruction in ID
- flags_in  in  4  {N,Z,C,V} from ALU
- exe_s  in  1  instruction in EXE sets flags (its registered s bit)
- exe_cmd  out  4  ALU command
- mem_r_en, mem_w_en, wb_en, b, s, imm  out  1 each  registered control
- shift_operand  out  12  instr[11:0], registered
- imm24  out  24  branch offset, registered
- dest  out  4  Rd, registered
- sr  out  4  status register {N,Z,C,V}; sr[1] drives ALU C_in
- two_src  out  1  combinational: instruction reads Rm/Rd as second source (to hazard unit)

## Operation
- Decode is valid only for instr[27:26] = 00 (data processing), 01 (LDR/STR) or 10 with instr[25] = 1 (B). Any other encoding decodes to a bubble.
- Data-processing opcode instr[24:21] maps to exe_cmd as follows:
  - MOV 1101 -> 0001; MVN 1111 -> 1001
  - ADD 0100 -> 0010; ADC 0101 -> 0011
  - SUB 0010 -> 0100; SBC 0110 -> 0101
  - AND 0000 -> 0110; ORR 1100 -> 0111; EOR 0001 -> 1000
  - CMP 1010 -> 0100; TST 1000 -> 0110
  - Unlisted opcodes decode to a bubble.
- wb_en = 1 for all data-processing ops except CMP and TST, which have wb_en = 0. For CMP and TST, s is forced to 1.
- For data processing, s = instr[20] and imm = instr[25].
- LDR (instr[20] = 1): exe_cmd = 0010, mem_r_en = 1, wb_en = 1. STR: exe_cmd = 0010, mem_w_en = 1, wb_en = 0. For both, s = 0 and imm = instr[25].
- B: b = 1, exe_cmd = 0000, no write-back.
- two_src = 1 for STR and for data processing with imm = 0, except MOV and MVN.
- Condition check against the effective flags. The effective flags are flags_in when exe_s = 1 and freeze = 0 (same-cycle bypass), else sr.
  - EQ/NE use Z; CS/CC use C; MI/PL use N; VS/VC use V.
  - HI = C & ~Z; LS = ~C | Z.
  - GE = N == V; LT = N != V.
  - GT = ~Z & (N == V); LE = Z | (N != V).
  - AL = 1; cond 1111 = fail.
- Bubble: all control outputs (exe_cmd, mem_r_en, mem_w_en, wb_en, b, s) are 0. Data fields (dest, imm24, shift_operand, imm) still load.
- SR update: on a rising edge with exe_s = 1 and freeze = 0, sr <= flags_in.

## Timing
- Reset: all registered outputs are 0 and sr = 0000, asynchronously.
- Latency: instr decoded in cycle n appears on the outputs in cycle n+1. two_src is combinational in the same cycle.
- Per-edge priority:
  1. flush: bubble, regardless of freeze. sr still obeys freeze.
  2. freeze: all outputs and sr hold.
  3. hazard, ~instr_valid, condition fail or invalid encoding: bubble.
  4. Otherwise the decoded control is loaded.
- A flush arriving together with a flag update: sr still updates, since the flags belong to the older instruction in EXE.
- Reset mid-stall: outputs clear immediately. The first post-reset edge behaves normally.

## Structure
- Shared package arm_pkg holds:
  - exe_cmd localparams: CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR
  - ARM opcode and cond-code constants
  - flag index constants N = 3, Z = 2, C = 1, V = 0
- One sub-module, cond_check: combinational, cond[3:0] and flags[3:0] in, pass out.
- The decoder, SR and ID/EXE register stay in id_exe_ctrl.

## Test plan
- ADDS R1,R2,#5 (E2921005), valid, no hazard -> next cycle exe_cmd = 0010, wb_en = 1, s = 1, imm = 1, dest = 1. After reset, all outputs are 0.
- CMP followed by BEQ: exe_s = 1 with flags_in = 0100 while BEQ (0A000003) is in ID -> bypass gives pass, b = 1, imm24 = 000003. The following edge gives sr = 0100.
- MOVNE (13A01001) with sr Z = 1, exe_s = 0 -> bubble (all control 0). With sr = 0000 -> exe_cmd = 0001, wb_en = 1.
- LDR (E5921000) with hazard = 1 -> bubble. With hazard = 0 -> mem_r_en = 1, exe_cmd = 0010, wb_en = 1, two_src = 0. STR (E5821000) -> mem_w_en = 1, wb_en = 0, two_src = 1.
- freeze = 1 for 3 cycles with exe_s = 1 -> outputs and sr unchanged. Asserting flush during the freeze -> bubble on the next edge.
- Assert rst mid-sequence, between clock edges -> outputs and sr are 0 immediately. TST (E1100002) afterwards -> exe_cmd = 0110, s = 1, wb_en = 0.
